// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: FSM state codes, opcode/funct
// values, ALU select encodings and the decoded instruction class.
package mips_pkg;

  // FSM state codes (plain constants for compatibility with older tooling)
  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Must match the ALU's operation decode
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsBeq,
    ClsLw,
    ClsSw,
    ClsJ
  } insn_cls_e;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decode: class, ALU select, write register and illegal flag.
module mips_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output insn_cls_e  cls,
  output logic [2:0] alu_sel,
  output logic [4:0] wr_reg,
  output logic       illegal
);

  // Map opcode/funct to instruction class and ALU operation
  always_comb begin
    cls     = ClsRtype;
    alu_sel = ALU_ADD;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls = ClsRtype;
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_BEQ: begin
        cls     = ClsBeq;
        alu_sel = ALU_SUB;
      end
      // Both read ports carry rt and AND passes it through unchanged as store data
      OP_SW: begin
        cls     = ClsSw;
        alu_sel = ALU_AND;
      end
      OP_LW:   cls = ClsLw;
      OP_J:    cls = ClsJ;
      default: illegal = 1'b1;
    endcase
  end

  // Loads write rt, R-type writes rd
  assign wr_reg = (op == OP_LW) ? rt : rd;

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle fetch/control FSM for a MIPS subset. Owns PC and IR, fetches over req/ack
// and sequences FETCH/DECODE/EXEC/MEM/WB. Optional macro MIPS_CTRL_PERF_EN adds
// cycle and retired-instruction counters.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic            alu_zf,
  input  logic [31:0]     alu_res,
  input  logic [31:0]     mem_dout,
  output logic [4:0]      br_a1,
  output logic [4:0]      br_a2,
  output logic [2:0]      alu_sel,
  output logic            mem_ewr,
  output logic [4:0]      mem_dir,
  output logic [4:0]      br_ddir,
  output logic [31:0]     br_din,
  output logic            br_ewr,
  output logic [PC_W-1:0] pc,
  output logic            halted
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt
`endif
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     res_q, res_d;

  insn_cls_e  cls;
  logic [2:0] dec_alu_sel;
  logic [4:0] wr_reg;
  logic       illegal;

  mips_decode u_decode (
    .op      (ir_q[31:26]),
    .funct   (ir_q[5:0]),
    .rt      (ir_q[20:16]),
    .rd      (ir_q[15:11]),
    .cls     (cls),
    .alu_sel (dec_alu_sel),
    .wr_reg  (wr_reg),
    .illegal (illegal)
  );

  logic [PC_W-1:0] pc_inc, br_off, j_tgt;
  assign pc_inc = pc_q + PC_W'(4);
  assign br_off = {{(PC_W - 18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_tgt  = {pc_q[PC_W-1:28], ir_q[25:0], 2'b00};

  // Next-state, PC, IR and result register update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_inc;
          state_d = StDecode;
        end
      end
      StDecode: state_d = illegal ? StHalt : StExec;
      StExec: begin
        case (cls)
          ClsRtype: begin
            res_d   = alu_res;
            state_d = StWb;
          end
          ClsBeq: begin
            // pc already points past the branch
            if (alu_zf) pc_d = pc_q + br_off;
            state_d = StFetch;
          end
          ClsJ: begin
            pc_d    = j_tgt;
            state_d = StFetch;
          end
          default: state_d = StMem;
        endcase
      end
      StMem: begin
        if (cls == ClsLw) begin
          res_d   = mem_dout;
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StHalt;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
    end
  end

  // Datapath controls; enables are masked by rst so an aborted op never writes
  always_comb begin
    imem_req = (state_q == StFetch) && !rst;
    mem_ewr  = (state_q == StMem) && (cls == ClsSw) && !rst;
    br_ewr   = (state_q == StWb) && !rst;
    br_a1    = ir_q[25:21];
    if ((cls == ClsSw) && ((state_q == StExec) || (state_q == StMem))) br_a1 = ir_q[20:16];
    br_a2    = ir_q[20:16];
    alu_sel  = dec_alu_sel;
    mem_dir  = ir_q[4:0];
    br_ddir  = wr_reg;
    br_din   = res_q;
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == StHalt);

`ifdef MIPS_CTRL_PERF_EN
  logic ret_evt;
  assign ret_evt = (state_d == StFetch) &&
                   ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

  // Free-running cycle count (frozen in HALT) and retired-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state_q != StHalt) cyc_cnt <= cyc_cnt + 32'd1;
      if (ret_evt)           ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle instruction fetch and control unit that sits directly upstream of the register-bank/ALU/memory datapath.
- Owns the PC and instruction register (IR), fetches instruction words over a req/ack handshake, and decodes a MIPS subset.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the datapath's read addresses, ALU select, memory write enable/address, and register write port.

Parameters:
- PC_W, 32, program counter width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  byte address of the fetch (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  32  instruction word, sampled when imem_req && imem_ack.
- alu_zf  in  1  ALU zero flag from the datapath.
- alu_res  in  32  ALU result from the datapath.
- mem_dout  in  32  data memory read data.
- br_a1  out  5  register read address 1.
- br_a2  out  5  register read address 2.
- alu_sel  out  3  ALU operation select.
- mem_ewr  out  1  data memory write enable.
- mem_dir  out  5  data memory word address.
- br_ddir  out  5  register write address.
- br_din  out  32  register write data.
- br_ewr  out  1  register write enable.
- pc  out  PC_W  current PC.
- halted  out  1  sticky; set on an illegal instruction.

Behaviour:
- Reset (rst sampled high at a clk edge): pc=RESET_PC, IR=0, state=FETCH, halted=0. All enables (imem_req, mem_ewr, br_ewr) are 0 in the cycle after reset; imem_req rises in FETCH on the following cycle. rst mid-instruction aborts it with no write issued.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are combinational functions of state and IR only.
- FETCH: imem_req=1, imem_addr=pc. Stays in FETCH while imem_ack=0. On ack: IR<=imem_data, pc<=pc+4, go to DECODE. An ack while imem_req=0 is ignored.
- DECODE: drives br_a1=IR[25:21] (rs) and br_a2=IR[20:16] (rt). Illegal opcode/funct goes to HALT and sets halted; otherwise goes to EXEC.
- EXEC, per instruction class:
  - R-type (op 0): alu_sel from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. res<=alu_res; go to WB.
  - beq (op 0x04): alu_sel=SUB. If alu_zf=1, pc<=pc+(sign-extended imm<<2), using the already-incremented pc. Go to FETCH.
  - sw (op 0x2B): br_a1=br_a2=rt, alu_sel=AND, so alu_res=rt. Go to MEM.
  - lw (op 0x23): go to MEM.
  - j (op 0x02): pc<={pc[PC_W-1:28], IR[25:0], 2'b00}. Go to FETCH.
- MEM: mem_dir=IR[4:0] (word address; imm[15:5] ignored).
  - sw: mem_ewr=1 for exactly one cycle, br_a1/br_a2/alu_sel held as in EXEC. Go to FETCH.
  - lw: res<=mem_dout. Go to WB.
- WB: br_ewr=1 for one cycle, br_din=res.
  - br_ddir=IR[15:11] for R-type, IR[20:16] for lw.
  - A write to register 0 is still issued; the register bank owns the r0 semantics.
  - Go to FETCH.
- HALT: absorbing state; all enables 0; only rst exits.
- Arithmetic: PC adds wrap modulo 2^PC_W; no alignment check.
- CPI: beq/j/sw take 3 or 4 cycles; R-type and lw take 4 or 5 cycles; each excludes fetch wait cycles.

Optional Feature:
- Macro MIPS_CTRL_PERF_EN.
- Defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0].
  - cyc_cnt increments every non-reset cycle except in HALT.
  - ret_cnt increments on each transition into FETCH from EXEC/MEM/WB.
  - Both clear on rst and wrap at 2^32.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - state enum.
  - opcode constants OP_RTYPE/OP_BEQ/OP_LW/OP_SW/OP_J.
  - funct constants.
  - ALU_SEL encodings: AND=3'd0, OR=3'd1, ADD=3'd2, SUB=3'd6, SLT=3'd7. These must match the ALU.
- One sub-module, mips_decode: purely combinational; maps IR to class, alu_sel, write-register and illegal flag. The FSM, PC and IR stay in mips_mc_ctrl.

Test Plan:
- Reset/fetch: rst 1 cycle, imem_ack delayed 3 cycles with data 0x012A4020 (add $8,$9,$10) -> imem_req held 4 cycles, pc=4, in WB br_ddir=8, alu_sel=2, br_ewr pulses once.
- Store: sw $5,3($0) with alu_res=0xDEADBEEF -> MEM cycle has br_a1=br_a2=5, alu_sel=0, mem_dir=3, mem_ewr high exactly 1 cycle, br_ewr never asserted.
- Load: lw $7,9($0) with mem_dout=0x12345678 -> WB has br_ddir=7, br_din=0x12345678.
- Branch: beq at pc=0x10 with imm=-2 -> alu_zf=1 gives next fetch addr 0x0C; alu_zf=0 gives 0x14.
- Illegal: opcode 0x3F -> halted=1, no further imem_req or write enables until rst; rst then restarts fetch at RESET_PC.
- Reset mid-op: rst asserted in MEM of a sw -> mem_ewr=0 that cycle and after, pc=RESET_PC.
